// File: rtl/spi_slave_if.sv
// Byte-side handshake between spi_slave and its producer/consumer (register wrapper or DMA).
// Transmit is valid/ready into a one-deep holding register; receive is hold/acknowledge.
interface spi_slave_if;
    logic [7:0] tx_data_i;
    logic       tx_valid_i;
    logic       tx_ready_o;
    logic [7:0] rx_data_o;
    logic       rx_valid_o;
    logic       rx_ack_i;

    modport slave (
        input  tx_data_i,
        input  tx_valid_i,
        output tx_ready_o,
        output rx_data_o,
        output rx_valid_o,
        input  rx_ack_i
    );

    modport master (
        output tx_data_i,
        output tx_valid_i,
        input  tx_ready_o,
        input  rx_data_o,
        input  rx_valid_o,
        output rx_ack_i
    );
endinterface

// File: rtl/spi_slave.sv
// Oversampled SPI slave: pins synchronised into clk_i, bytes exchanged over spi_slave_if.
// Define SPI_SLAVE_STATUS_EN to implement the sticky overrun/underrun flags.
module spi_slave #(
    parameter bit       CPOL       = 1'b0,
    parameter bit       CPHA       = 1'b0,
    parameter bit [7:0] DEFAULT_TX = 8'hFF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       spi_clk_i,
    input  logic       spi_ss_i,
    input  logic       spi_mosi_i,
    output logic       spi_miso_o,
    output logic       spi_miso_oe_o,
    spi_slave_if.slave bus,
    output logic       busy_o,
    output logic       overrun_o,
    output logic       underrun_o
);

    typedef enum logic [0:0] {StIdle, StActive} state_e;

    // [0] metastable, [1] synchronised, [2] history for edge detection
    logic [2:0] sclk_q, ss_q, mosi_q;

    state_e     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic       byte_done_q, byte_done_d;
    logic [7:0] tx_hold_q, tx_hold_d;
    logic       tx_full_q, tx_full_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;

    logic lead_edge, trail_edge, sample_edge, shift_edge, ss_fall, load_point;

    assign lead_edge   = (sclk_q[2] == CPOL) && (sclk_q[1] != CPOL);
    assign trail_edge  = (sclk_q[2] != CPOL) && (sclk_q[1] == CPOL);
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge : trail_edge;
    assign ss_fall     = ss_q[2] & ~ss_q[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_q      <= {3{CPOL}};
            ss_q        <= 3'b111;
            mosi_q      <= '0;
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            byte_done_q <= 1'b0;
            tx_hold_q   <= '0;
            tx_full_q   <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
        end else begin
            sclk_q      <= {sclk_q[1:0], spi_clk_i};
            ss_q        <= {ss_q[1:0], spi_ss_i};
            mosi_q      <= {mosi_q[1:0], spi_mosi_i};
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            byte_done_q <= byte_done_d;
            tx_hold_q   <= tx_hold_d;
            tx_full_q   <= tx_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        byte_done_d = 1'b0;
        load_point  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d   = StActive;
                    bit_cnt_d = '0;
                    if (!CPHA) begin
                        load_point = 1'b1;
                    end
                end
            end
            StActive: begin
                if (ss_q[1]) begin
                    state_d    = StIdle;
                    bit_cnt_d  = '0;
                    rx_shift_d = '0;
                    tx_shift_d = '0;
                end else begin
                    if (sample_edge) begin
                        rx_shift_d  = {rx_shift_q[6:0], mosi_q[2]};
                        bit_cnt_d   = bit_cnt_q + 3'd1;
                        byte_done_d = (bit_cnt_q == 3'd7);
                    end
                    // A shift edge at a byte boundary reloads instead of shifting.
                    if (shift_edge) begin
                        if (bit_cnt_q == 3'd0) begin
                            load_point = 1'b1;
                        end else begin
                            tx_shift_d = {tx_shift_q[6:0], 1'b0};
                        end
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (load_point) begin
            tx_shift_d = tx_full_q ? tx_hold_q : DEFAULT_TX;
        end
    end

    // Holding register and rx handshake; a consume takes the old contents, a same-cycle
    // write lands in the holding register afterwards.
    always_comb begin
        tx_hold_d  = tx_hold_q;
        tx_full_d  = tx_full_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;

        if (load_point) begin
            tx_full_d = 1'b0;
        end
        if (bus.tx_valid_i && !tx_full_q) begin
            tx_hold_d = bus.tx_data_i;
            tx_full_d = 1'b1;
        end

        if (byte_done_q) begin
            rx_data_d  = rx_shift_q;
            rx_valid_d = 1'b1;
        end else if (bus.rx_ack_i) begin
            rx_valid_d = 1'b0;
        end
    end

`ifdef SPI_SLAVE_STATUS_EN
    logic overrun_q, underrun_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overrun_q  <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (byte_done_q && rx_valid_q && !bus.rx_ack_i) begin
                overrun_q <= 1'b1;
            end
            if (load_point && !tx_full_q) begin
                underrun_q <= 1'b1;
            end
        end
    end

    assign overrun_o  = overrun_q;
    assign underrun_o = underrun_q;
`else
    assign overrun_o  = 1'b0;
    assign underrun_o = 1'b0;
`endif

    assign busy_o         = (state_q == StActive);
    assign spi_miso_oe_o  = busy_o;
    assign spi_miso_o     = busy_o ? tx_shift_q[7] : DEFAULT_TX[7];
    assign bus.tx_ready_o = ~tx_full_q;
    assign bus.rx_data_o  = rx_data_q;
    assign bus.rx_valid_o = rx_valid_q;

endmodule
